// File: rtl/pong_pkg.sv
// Shared definitions for the Pong input stage: debounce FSM encoding,
// arbitration priority and the board-derived debounce default.
package pong_pkg;

  localparam logic [1:0] ST_RELEASED     = 2'd0;
  localparam logic [1:0] ST_PRESS_WAIT   = 2'd1;
  localparam logic [1:0] ST_PRESSED      = 2'd2;
  localparam logic [1:0] ST_RELEASE_WAIT = 2'd3;

  typedef enum logic [1:0] {
    RELEASED     = ST_RELEASED,
    PRESS_WAIT   = ST_PRESS_WAIT,
    PRESSED      = ST_PRESSED,
    RELEASE_WAIT = ST_RELEASE_WAIT
  } key_state_e;

  typedef enum logic {
    PRIO_UP   = 1'b0,
    PRIO_DOWN = 1'b1
  } prio_e;

  // 20 ms of stable input at the 50 MHz board clock.
  localparam int unsigned CLK_HZ                  = 50_000_000;
  localparam int unsigned DEBOUNCE_MS             = 20;
  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = (CLK_HZ / 1000) * DEBOUNCE_MS;

endpackage

// File: rtl/key_debouncer.sv
// One push-button channel: pin synchronizer, debounce FSM with restart-on-bounce
// counter, debounced level and a one-cycle accepted-press flag.
module key_debouncer
  import pong_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter bit          KEY_ACTIVE_LOW  = 1'b1
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_key,
  output logic o_level,
  output logic o_press_pulse
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_s;
  key_state_e             r_state;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_press;

  // Synchronizer resets to the idle pin level so a held key re-qualifies after reset.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sync <= {SYNC_STAGES{KEY_ACTIVE_LOW}};
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_key};
    end
  end

  assign w_s = r_sync[SYNC_STAGES-1] ^ KEY_ACTIVE_LOW;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= RELEASED;
      r_cnt   <= '0;
      r_press <= 1'b0;
    end else begin
      r_press <= 1'b0;
      case (r_state)
        RELEASED: begin
          if (w_s) begin
            r_state <= PRESS_WAIT;
            r_cnt   <= CNT_ONE;
          end
        end
        PRESS_WAIT: begin
          if (!w_s) begin
            r_state <= RELEASED;
            r_cnt   <= '0;
          end else if (r_cnt == CNT_MAX) begin
            r_state <= PRESSED;
            r_cnt   <= '0;
            r_press <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        PRESSED: begin
          if (!w_s) begin
            r_state <= RELEASE_WAIT;
            r_cnt   <= CNT_ONE;
          end
        end
        RELEASE_WAIT: begin
          if (w_s) begin
            r_state <= PRESSED;
            r_cnt   <= '0;
          end else if (r_cnt == CNT_MAX) begin
            r_state <= RELEASED;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
        default: begin
          r_state <= RELEASED;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign o_level       = (r_state == PRESSED) || (r_state == RELEASE_WAIT);
  assign o_press_pulse = r_press;

endmodule

// File: rtl/paddle_key_conditioner.sv
// Conditions the two paddle buttons into mutually exclusive raket_up/raket_down
// levels, with last-press-wins arbitration and one-cycle press strobes.
module paddle_key_conditioner
  import pong_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter bit          KEY_ACTIVE_LOW  = 1'b1
) (
  input  logic inClock,
  input  logic reset,
  input  logic keyUpN,
  input  logic keyDownN,
  output logic raket_up,
  output logic raket_down,
  output logic upPress,
  output logic downPress
);

  logic  w_up_level;
  logic  w_up_press;
  logic  w_down_level;
  logic  w_down_press;
  prio_e w_prio_next;
  prio_e r_prio;
  logic  r_up;
  logic  r_down;
  logic  r_up_press;
  logic  r_down_press;

  key_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .SYNC_STAGES    (SYNC_STAGES),
    .KEY_ACTIVE_LOW (KEY_ACTIVE_LOW)
  ) u_up (
    .i_clk        (inClock),
    .i_reset      (reset),
    .i_key        (keyUpN),
    .o_level      (w_up_level),
    .o_press_pulse(w_up_press)
  );

  key_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .SYNC_STAGES    (SYNC_STAGES),
    .KEY_ACTIVE_LOW (KEY_ACTIVE_LOW)
  ) u_down (
    .i_clk        (inClock),
    .i_reset      (reset),
    .i_key        (keyDownN),
    .o_level      (w_down_level),
    .o_press_pulse(w_down_press)
  );

  // Arbitrate with the updated priority so a fresh press wins on its own edge.
  always_comb begin
    w_prio_next = r_prio;
    if (w_up_press) begin
      w_prio_next = PRIO_UP;
    end else if (w_down_press) begin
      w_prio_next = PRIO_DOWN;
    end
  end

  always_ff @(posedge inClock) begin
    if (reset) begin
      r_prio       <= PRIO_UP;
      r_up         <= 1'b0;
      r_down       <= 1'b0;
      r_up_press   <= 1'b0;
      r_down_press <= 1'b0;
    end else begin
      r_prio       <= w_prio_next;
      r_up         <= w_up_level && (!w_down_level || (w_prio_next == PRIO_UP));
      r_down       <= w_down_level && (!w_up_level || (w_prio_next == PRIO_DOWN));
      r_up_press   <= w_up_press;
      r_down_press <= w_down_press;
    end
  end

  assign raket_up   = r_up;
  assign raket_down = r_down;
  assign upPress    = r_up_press;
  assign downPress  = r_down_press;

endmodule
